// File: rtl/agex_muldiv_seq_pkg.sv
// Shared op codes, state encodings and AGEX<->MD bus widths for the iterative mul/div sequencer.
package agex_muldiv_seq_pkg;

    localparam int MDOPBITS = 3;
    localparam int MD_DBITS = 32;

    typedef enum logic [MDOPBITS-1:0] {
        MD_OP_MUL    = 3'd0,
        MD_OP_MULH   = 3'd1,
        MD_OP_MULHSU = 3'd2,
        MD_OP_MULHU  = 3'd3,
        MD_OP_DIV    = 3'd4,
        MD_OP_DIVU   = 3'd5,
        MD_OP_REM    = 3'd6,
        MD_OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // {req_valid, req_op, req_src1, req_src2, flush} and {res_valid, res_data, stall_AGEX}
    localparam int FROM_AGEX_TO_MD_WIDTH = 1 + MDOPBITS + 2*MD_DBITS + 1;
    localparam int FROM_MD_TO_AGEX_WIDTH = 1 + MD_DBITS + 1;

    function automatic logic md_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic md_src1_signed(input md_op_e op);
        return (op == MD_OP_MUL) || (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
               (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

    function automatic logic md_src2_signed(input md_op_e op);
        return (op == MD_OP_MUL) || (op == MD_OP_MULH) ||
               (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/agex_muldiv_step.sv
// One combinational iteration: shift-add multiply on {hi, lo} or restoring divide on {rem=hi, quot=lo}.
module agex_muldiv_step #(
    parameter int DBITS = 32
) (
    input  logic             is_div,
    input  logic [DBITS-1:0] hi,
    input  logic [DBITS-1:0] lo,
    input  logic [DBITS-1:0] b,
    output logic [DBITS-1:0] hi_next,
    output logic [DBITS-1:0] lo_next
);

    logic [DBITS:0] sum;
    logic [DBITS:0] shifted;
    logic [DBITS:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        shifted = {hi, lo[DBITS-1]};
        diff    = shifted - {1'b0, b};
        hi_next = sum[DBITS:1];
        lo_next = {sum[0], lo[DBITS-1:1]};
        if (is_div) begin
            // rem < divisor keeps diff below 2^DBITS, so the top bit is a pure borrow flag
            if (!diff[DBITS]) begin
                hi_next = diff[DBITS-1:0];
                lo_next = {lo[DBITS-2:0], 1'b1};
            end else begin
                hi_next = shifted[DBITS-1:0];
                lo_next = {lo[DBITS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/agex_muldiv_seq.sv
// RV32M iterative multiply/divide sequencer beside the AGEX ALU; stalls AGEX until the result is taken.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero finish at accept.
module agex_muldiv_seq
    import agex_muldiv_seq_pkg::*;
#(
    parameter int DBITS   = 32,
    parameter int CNTBITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [MDOPBITS-1:0] req_op,
    input  logic [DBITS-1:0]    req_src1,
    input  logic [DBITS-1:0]    req_src2,
    input  logic                flush,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DBITS-1:0]    res_data,
    output logic                stall_AGEX
);

    md_state_e          state, state_next;
    md_op_e             op, op_in;
    logic [CNTBITS-1:0] cnt;
    logic [DBITS-1:0]   hi, lo, b;
    logic [DBITS-1:0]   hi_next, lo_next;
    logic               neg;

    logic               accept, last;
    logic               s1, s2, div_zero, neg_in;
    logic [DBITS-1:0]   mag1, mag2;
    logic               early_hit;
    logic [DBITS-1:0]   early_data;
    logic [2*DBITS-1:0] prod, prod_fix;
    logic [DBITS-1:0]   quot_fix, rem_fix, final_data;

    assign op_in  = md_op_e'(req_op);
    assign accept = (state == MD_IDLE) && req_valid && !flush;
    assign last   = (cnt == CNTBITS'(DBITS-1));

    // Operand magnitudes and result sign captured at accept
    always_comb begin
        s1       = md_src1_signed(op_in) & req_src1[DBITS-1];
        s2       = md_src2_signed(op_in) & req_src2[DBITS-1];
        mag1     = s1 ? -req_src1 : req_src1;
        mag2     = s2 ? -req_src2 : req_src2;
        div_zero = (req_src2 == '0);
        case (op_in)
            MD_OP_MUL, MD_OP_MULH: neg_in = s1 ^ s2;
            MD_OP_MULHSU:          neg_in = s1;
            MD_OP_DIV:             neg_in = !div_zero && (s1 ^ s2);
            MD_OP_REM:             neg_in = s1;
            default:               neg_in = 1'b0;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        early_hit  = md_is_div(op_in) ? div_zero : (req_src1 == '0) || div_zero;
        early_data = '0;
        if (op_in == MD_OP_DIV || op_in == MD_OP_DIVU)
            early_data = '1;
        else if (op_in == MD_OP_REM || op_in == MD_OP_REMU)
            early_data = req_src1;
    end
`else
    assign early_hit  = 1'b0;
    assign early_data = '0;
`endif

    agex_muldiv_step #(.DBITS(DBITS)) u_step (
        .is_div  (md_is_div(op)),
        .hi      (hi),
        .lo      (lo),
        .b       (b),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Sign fixup applied to the outcome of the final iteration
    always_comb begin
        prod     = {hi_next, lo_next};
        prod_fix = neg ? -prod : prod;
        quot_fix = neg ? -lo_next : lo_next;
        rem_fix  = neg ? -hi_next : hi_next;
        case (op)
            MD_OP_MUL:                            final_data = prod_fix[DBITS-1:0];
            MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: final_data = prod_fix[2*DBITS-1:DBITS];
            MD_OP_DIV, MD_OP_DIVU:                final_data = quot_fix;
            default:                              final_data = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (accept) state_next = early_hit ? MD_DONE : MD_RUN;
            MD_RUN:  if (flush) state_next = MD_IDLE;
                     else if (last) state_next = MD_DONE;
            MD_DONE: if (flush || res_ready) state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == MD_IDLE);
        stall_AGEX = (req_valid && state != MD_DONE) || (state == MD_RUN) ||
                     (state == MD_DONE && !res_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op        <= MD_OP_MUL;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            b         <= '0;
            neg       <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                MD_IDLE: if (accept) begin
                    op  <= op_in;
                    cnt <= '0;
                    hi  <= '0;
                    lo  <= mag1;
                    b   <= mag2;
                    neg <= neg_in;
                    if (early_hit) begin
                        res_valid <= 1'b1;
                        res_data  <= early_data;
                    end
                end
                MD_RUN: if (flush) begin
                    cnt <= '0;
                end else begin
                    hi <= hi_next;
                    lo <= lo_next;
                    if (last) begin
                        cnt       <= '0;
                        res_valid <= 1'b1;
                        res_data  <= final_data;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MD_DONE: if (flush || res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
